// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter: grants one requester at a time, holds the grant until
// done, request drop or hold limit, then rotates priority past the last owner.
module rr_req_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned IDW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    localparam int unsigned CW = $clog2(MAX_HOLD) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   gnt_d;
    logic [IDW-1:0] gnt_id_d;
    logic           busy_d;
    logic           timeout_d;

    // Rotating-priority winner search and owner release evaluation
    always_comb begin
        logic           found;
        logic [IDW-1:0] win;
        logic           at_limit;
        logic           owner_req;
        int unsigned    idx;

        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt;
        gnt_id_d  = gnt_id;
        busy_d    = busy;
        timeout_d = 1'b0;
        found     = 1'b0;
        win       = '0;
        idx       = 0;
        at_limit  = (cnt_q == CW'(MAX_HOLD - 1));
        owner_req = req[gnt_id];

        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr_q) + i) % N;
            if (!found && req[IDW'(idx)]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end

        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (found) begin
                    gnt_d    = N'(1) << win;
                    gnt_id_d = win;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (done || !owner_req || at_limit) begin
                    // done and request-drop outrank the hold limit
                    timeout_d = !done && owner_req && at_limit;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    ptr_d     = IDW'((32'(gnt_id) + 32'd1) % N);
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            gnt_id  <= gnt_id_d;
            busy    <= busy_d;
            timeout <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Self-checking bench for rr_req_arbiter: directed vector table, hand-written
// hold-limit sequences, and randomized traffic against a behavioural model.
module tb_rr_req_arbiter;

    localparam int unsigned N        = 4;
    localparam int unsigned MAX_HOLD = 8;
    localparam int unsigned IDW      = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic           done = 1'b0;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;

    int errors = 0;
    int checks = 0;

    // Behavioural model: who owns the resource, how long, and where the
    // rotation resumes.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_last  = 0;
    int m_held  = 0;
    int m_to    = 0;

    typedef struct {
        bit       rst;
        bit [3:0] req;
        bit       done;
        bit [3:0] gnt;
        int       id;
        bit       busy;
        bit       to;
    } vec_t;

    vec_t tbl[$];

    rr_req_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit [3:0] rq, bit d, bit [3:0] g, int id, bit b, bit t);
        vec_t v;
        v.rst = r; v.req = rq; v.done = d; v.gnt = g; v.id = id; v.busy = b; v.to = t;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input logic [N-1:0] rq, input bit d);
        m_to = 0;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_last = 0; m_held = 0;
        end else if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (m_owner < 0 && rq[k]) m_owner = k;
            end
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_held = 1;
            end
        end else if (d || !rq[m_owner] || m_held == MAX_HOLD) begin
            if (!d && rq[m_owner]) m_to = 1;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else begin
            m_held++;
        end
    endtask

    // One clock: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input bit r, input logic [N-1:0] rq, input bit d, input string tag);
        int exp_gnt;
        @(negedge clk);
        rst = r; req = rq; done = d;
        @(posedge clk);
        model_edge(r, rq, d);
        #1;
        exp_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
        chk({tag, ".gnt"},     int'(gnt), exp_gnt);
        chk({tag, ".gnt_id"},  int'(gnt_id), m_last);
        chk({tag, ".busy"},    int'(busy), (m_owner >= 0) ? 1 : 0);
        chk({tag, ".timeout"}, int'(timeout), m_to);
        chk({tag, ".onehot"},  ($countones(gnt) <= 1) ? 1 : 0, 1);
        chk({tag, ".busy_or"}, int'(busy), int'(|gnt));
    endtask

    initial begin
        // Directed vectors: inputs before the edge, outputs expected after it
        tbl.push_back(mk(1, 4'b1111, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 0, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 0, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0100, 2, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0100, 2, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 2, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b1000, 3, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b1000, 3, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 3, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 0, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0100, 2, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 2, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 2, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 0, 4'b1000, 3, 1, 0));
        tbl.push_back(mk(1, 4'b1000, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1001, 0, 4'b0001, 0, 1, 0));
        tbl.push_back(mk(0, 4'b1001, 1, 4'b0000, 0, 0, 0));

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(tbl[i].rst, tbl[i].req, tbl[i].done, tag);
            chk({tag, ".tbl_gnt"}, int'(gnt), int'(tbl[i].gnt));
            chk({tag, ".tbl_id"},  int'(gnt_id), tbl[i].id);
            chk({tag, ".tbl_busy"}, int'(busy), int'(tbl[i].busy));
            chk({tag, ".tbl_to"},  int'(timeout), int'(tbl[i].to));
        end

        // Hold limit: requester 2 keeps asking, grant lasts MAX_HOLD cycles
        for (int i = 0; i < MAX_HOLD; i++) begin
            step(0, 4'b0100, 0, $sformatf("hold%0d", i));
            chk($sformatf("hold%0d.const_gnt", i), int'(gnt), 4);
            chk($sformatf("hold%0d.const_to", i), int'(timeout), 0);
        end
        step(0, 4'b0100, 0, "hold_rel");
        chk("hold_rel.const_gnt", int'(gnt), 0);
        chk("hold_rel.const_to", int'(timeout), 1);
        step(0, 4'b0100, 0, "hold_regrant");
        chk("hold_regrant.const_gnt", int'(gnt), 4);
        chk("hold_regrant.const_to", int'(timeout), 0);

        // done coinciding with the last permitted hold cycle suppresses timeout
        for (int i = 1; i < MAX_HOLD; i++) begin
            step(0, 4'b0100, 0, $sformatf("dlim%0d", i));
            chk($sformatf("dlim%0d.const_gnt", i), int'(gnt), 4);
        end
        step(0, 4'b0100, 1, "dlim_rel");
        chk("dlim_rel.const_gnt", int'(gnt), 0);
        chk("dlim_rel.const_to", int'(timeout), 0);
        chk("dlim_rel.const_id", int'(gnt_id), 2);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] rq;
            bit           d;
            bit           r;
            rq = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rq = '0;
            d  = ($urandom_range(0, 9) < 2);
            r  = ($urandom_range(0, 99) == 0);
            step(r, rq, d, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
